// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor: exhaustive on-chip self-test engine for approximate
// unsigned multipliers. Sweeps every operand pair, aligns each returned product
// with its operands, and accumulates error count, overshoot count, saturating
// error-distance sum and the first worst-case pair.
// Optional feature macro: ERR_MON_BIAS_EN adds a signed, saturating bias_sum
// output accumulating (exact - mul_r).
module approx_mul_err_monitor #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 0,
    parameter int CONF_W  = 6,
    parameter int SUM_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CONF_W-1:0]    conf_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [CONF_W-1:0]    mul_conf,
    input  logic [2*WIDTH-1:0]   mul_r,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [2*WIDTH:0]     over_cnt,
    output logic [SUM_W-1:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b
`ifdef ERR_MON_BIAS_EN
    ,
    output logic signed [SUM_W:0] bias_sum
`endif
);

    localparam int PROD_W  = 2 * WIDTH;
    localparam int CNT_W   = 2 * WIDTH + 1;
    localparam int SUM_X   = SUM_W + 1;
    localparam int ENTRY_W = 2 * WIDTH + 1;
    localparam int DRN_W   = $clog2(MUL_LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               accept;
    logic               issue;
    logic               last_pair;

    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [CONF_W-1:0]  conf_q, conf_d;

    logic               aligned_valid;
    logic [WIDTH-1:0]   aligned_a;
    logic [WIDTH-1:0]   aligned_b;

    logic               cmp_valid_q, cmp_valid_d;
    logic [WIDTH-1:0]   cmp_a_q, cmp_a_d;
    logic [WIDTH-1:0]   cmp_b_q, cmp_b_d;
    logic [PROD_W-1:0]  cmp_r_q, cmp_r_d;

    logic [PROD_W-1:0]  exact;
    logic               is_over;
    logic [PROD_W-1:0]  ed;
    logic [SUM_X-1:0]   sum_ext;

    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   over_cnt_q, over_cnt_d;
    logic [SUM_W-1:0]   sum_ed_q, sum_ed_d;
    logic [PROD_W-1:0]  max_ed_q, max_ed_d;
    logic [WIDTH-1:0]   max_a_q, max_a_d;
    logic [WIDTH-1:0]   max_b_q, max_b_d;

`ifdef ERR_MON_BIAS_EN
    localparam int BIAS_W = SUM_W + 1;
    localparam int BIAS_X = SUM_W + 2;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic signed [PROD_W:0]   diff;
    logic signed [BIAS_X-1:0] bias_ext;

    assign diff     = $signed({1'b0, exact}) - $signed({1'b0, cmp_r_q});
    assign bias_ext = BIAS_X'(bias_q) + BIAS_X'(diff);
    assign bias_sum = bias_q;
`endif

    assign last_pair = (mul_a_q == '1) && (mul_b_q == '1);
    assign busy      = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

    // Control state register and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic: accept start in IDLE, issue one pair per SWEEP cycle, flush in DRAIN.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        accept      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                issue = 1'b1;
                if (last_pair) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRN_W'(MUL_LAT)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand counter (B inner, A outer) and configuration latch.
    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        conf_d  = conf_q;
        if (accept) begin
            mul_a_d = '0;
            mul_b_d = '0;
            conf_d  = conf_in;
        end else if (issue) begin
            {mul_a_d, mul_b_d} = {mul_a_q, mul_b_q} + PROD_W'(1);
        end
    end

    // Delay line that lines the issued operands up with the multiplier's result.
    generate
        if (MUL_LAT == 0) begin : g_no_dly
            assign aligned_valid = issue;
            assign aligned_a     = mul_a_q;
            assign aligned_b     = mul_b_q;
        end else begin : g_dly
            logic [ENTRY_W-1:0] dly_q [MUL_LAT];
            logic [ENTRY_W-1:0] dly_d [MUL_LAT];

            // Shift a new {valid, a, b} entry in each cycle.
            always_comb begin
                dly_d[0] = {issue, mul_a_q, mul_b_q};
                for (int i = 1; i < MUL_LAT; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            // Delay-line registers; cleared on reset so an aborted sweep leaves nothing behind.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < MUL_LAT; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign {aligned_valid, aligned_a, aligned_b} = dly_q[MUL_LAT-1];
        end
    endgenerate

    // Compare stage captures the aligned {a, b, mul_r} triple.
    always_comb begin
        cmp_valid_d = aligned_valid;
        cmp_a_d     = aligned_a;
        cmp_b_d     = aligned_b;
        cmp_r_d     = mul_r;
    end

    assign exact   = PROD_W'(cmp_a_q) * PROD_W'(cmp_b_q);
    assign is_over = cmp_r_q > exact;
    assign ed      = is_over ? (cmp_r_q - exact) : (exact - cmp_r_q);
    assign sum_ext = {1'b0, sum_ed_q} + SUM_X'(ed);

    // Accumulator updates: cleared by an accepted start, otherwise fed by each valid compare.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        over_cnt_d = over_cnt_q;
        sum_ed_d   = sum_ed_q;
        max_ed_d   = max_ed_q;
        max_a_d    = max_a_q;
        max_b_d    = max_b_q;
`ifdef ERR_MON_BIAS_EN
        bias_d     = bias_q;
`endif
        if (accept) begin
            err_cnt_d  = '0;
            over_cnt_d = '0;
            sum_ed_d   = '0;
            max_ed_d   = '0;
            max_a_d    = '0;
            max_b_d    = '0;
`ifdef ERR_MON_BIAS_EN
            bias_d     = '0;
`endif
        end else if (cmp_valid_q) begin
            if (ed != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (is_over) begin
                over_cnt_d = over_cnt_q + CNT_W'(1);
            end
            sum_ed_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            if (ed > max_ed_q) begin
                max_ed_d = ed;
                max_a_d  = cmp_a_q;
                max_b_d  = cmp_b_q;
            end
`ifdef ERR_MON_BIAS_EN
            if (bias_ext[BIAS_X-1] != bias_ext[BIAS_X-2]) begin
                bias_d = bias_ext[BIAS_X-1] ? {1'b1, {(BIAS_W-1){1'b0}}}
                                            : {1'b0, {(BIAS_W-1){1'b1}}};
            end else begin
                bias_d = bias_ext[BIAS_W-1:0];
            end
`endif
        end
    end

    // Datapath registers: operands, configuration, compare stage and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            conf_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_r_q     <= '0;
            err_cnt_q   <= '0;
            over_cnt_q  <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
`ifdef ERR_MON_BIAS_EN
            bias_q      <= '0;
`endif
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            conf_q      <= conf_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            cmp_r_q     <= cmp_r_d;
            err_cnt_q   <= err_cnt_d;
            over_cnt_q  <= over_cnt_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
            max_a_q     <= max_a_d;
            max_b_q     <= max_b_d;
`ifdef ERR_MON_BIAS_EN
            bias_q      <= bias_d;
`endif
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign mul_conf = conf_q;
    assign err_cnt  = err_cnt_q;
    assign over_cnt = over_cnt_q;
    assign sum_ed   = sum_ed_q;
    assign max_ed   = max_ed_q;
    assign max_a    = max_a_q;
    assign max_b    = max_b_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Testbench for approx_mul_err_monitor, using a reduced 4-bit sweep with a
// 3-cycle external multiplier and a narrow accumulator so sum_ed saturates.
module tb_approx_mul_err_monitor;

    localparam int WIDTH    = 4;
    localparam int MUL_LAT  = 3;
    localparam int CONF_W   = 6;
    localparam int SUM_W    = 12;
    localparam int N_PAIRS  = 1 << (2 * WIDTH);
    localparam int BUSY_LEN = N_PAIRS + MUL_LAT + 1;
    localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;

    // Multiplier behaviours: 0 exact, 1 zero, 2 plus-one, 3 clear LSB, 4 set LSB
    localparam int M_EXACT = 0;
    localparam int M_ZERO  = 1;
    localparam int M_PLUS1 = 2;
    localparam int M_CLR0  = 3;
    localparam int M_SET0  = 4;

    typedef struct {
        int err;
        int over;
        int sum;
        int max_ed;
        int max_a;
        int max_b;
    } res_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [CONF_W-1:0]   conf_in = '0;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    mul_a;
    logic [WIDTH-1:0]    mul_b;
    logic [CONF_W-1:0]   mul_conf;
    logic [2*WIDTH-1:0]  mul_r;
    logic [2*WIDTH:0]    err_cnt;
    logic [2*WIDTH:0]    over_cnt;
    logic [SUM_W-1:0]    sum_ed;
    logic [2*WIDTH-1:0]  max_ed;
    logic [WIDTH-1:0]    max_a;
    logic [WIDTH-1:0]    max_b;
`ifdef ERR_MON_BIAS_EN
    logic signed [SUM_W:0] bias_sum;
`endif

    int                  total = 0;
    int                  bad = 0;
    int                  mode = M_EXACT;
    res_t                exp_res;
    logic [CONF_W-1:0]   exp_conf = '0;
    int                  run_len = 0;
    int                  done_pulses = 0;
    logic [WIDTH-1:0]    pa [MUL_LAT];
    logic [WIDTH-1:0]    pb [MUL_LAT];

    approx_mul_err_monitor #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .CONF_W  (CONF_W),
        .SUM_W   (SUM_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .conf_in  (conf_in),
        .busy     (busy),
        .done     (done),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_conf (mul_conf),
        .mul_r    (mul_r),
        .err_cnt  (err_cnt),
        .over_cnt (over_cnt),
        .sum_ed   (sum_ed),
        .max_ed   (max_ed),
        .max_a    (max_a),
        .max_b    (max_b)
`ifdef ERR_MON_BIAS_EN
        ,
        .bias_sum (bias_sum)
`endif
    );

    always #5 clk = ~clk;

    // Behaviour of the approximate multiplier being characterised.
    function automatic int approxOut(input int m, input int a, input int b);
        int p;
        p = a * b;
        case (m)
            M_ZERO:  return 0;
            M_PLUS1: return p + 1;
            M_CLR0:  return p & ~1;
            M_SET0:  return p | 1;
            default: return p;
        endcase
    endfunction

    // Expected sweep results straight from the error-metric definitions.
    function automatic res_t modelSweep(input int m);
        res_t   r;
        longint s;
        int     ex;
        int     got;
        int     d;
        r.err = 0; r.over = 0; r.sum = 0; r.max_ed = 0; r.max_a = 0; r.max_b = 0;
        s = 0;
        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
                ex  = a * b;
                got = approxOut(m, a, b);
                d   = (ex > got) ? ex - got : got - ex;
                if (d != 0) r.err++;
                if (got > ex) r.over++;
                s += d;
                if (d > r.max_ed) begin
                    r.max_ed = d;
                    r.max_a  = a;
                    r.max_b  = b;
                end
            end
        end
        r.sum = int'((s > SUM_MAX) ? SUM_MAX : s);
        return r;
    endfunction

    // External multiplier with MUL_LAT cycles of pipeline delay.
    always @(posedge clk) begin
        pa[0] <= mul_a;
        pb[0] <= mul_b;
        for (int i = 1; i < MUL_LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end

    always_comb begin
        mul_r = (2*WIDTH)'(approxOut(mode, int'(pa[MUL_LAT-1]), int'(pb[MUL_LAT-1])));
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Per-cycle compare: operand sequence, latched mask, busy length and final results.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                checkOutput("mul_conf_held", longint'(mul_conf), longint'(exp_conf));
                if (run_len < N_PAIRS) begin
                    checkOutput("operand_seq", longint'({mul_a, mul_b}), longint'(run_len));
                end
                run_len++;
            end else if (done) begin
                done_pulses++;
                checkOutput("busy_len", longint'(run_len), longint'(BUSY_LEN));
                checkOutput("m_err_cnt", longint'(err_cnt), longint'(exp_res.err));
                checkOutput("m_over_cnt", longint'(over_cnt), longint'(exp_res.over));
                checkOutput("m_sum_ed", longint'(sum_ed), longint'(exp_res.sum));
                checkOutput("m_max_ed", longint'(max_ed), longint'(exp_res.max_ed));
                checkOutput("m_max_a", longint'(max_a), longint'(exp_res.max_a));
                checkOutput("m_max_b", longint'(max_b), longint'(exp_res.max_b));
                run_len = 0;
            end else begin
                run_len = 0;
            end
        end
    end

    // Select a multiplier behaviour and issue a one-cycle start with the given mask.
    task automatic applyStimulus(input int m, input logic [CONF_W-1:0] conf);
        @(posedge clk);
        #1;
        mode     = m;
        exp_res  = modelSweep(m);
        exp_conf = conf;
        conf_in  = conf;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Wait (bounded) for the done pulse; leaves the caller at the negedge of the DONE cycle.
    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUSY_LEN + 50 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, longint'(seen), 1);
    endtask

    task automatic checkLiteral(input string name, input int e, input int o, input int s,
                                input int me, input int ma, input int mb);
        checkOutput({name, "_err_cnt"}, longint'(err_cnt), longint'(e));
        checkOutput({name, "_over_cnt"}, longint'(over_cnt), longint'(o));
        checkOutput({name, "_sum_ed"}, longint'(sum_ed), longint'(s));
        checkOutput({name, "_max_ed"}, longint'(max_ed), longint'(me));
        checkOutput({name, "_max_a"}, longint'(max_a), longint'(ma));
        checkOutput({name, "_max_b"}, longint'(max_b), longint'(mb));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, longint'(busy), 0);
        checkOutput({name, "_done"}, longint'(done), 0);
        checkOutput({name, "_mul_a"}, longint'(mul_a), 0);
        checkOutput({name, "_mul_b"}, longint'(mul_b), 0);
        checkOutput({name, "_mul_conf"}, longint'(mul_conf), 0);
        checkLiteral(name, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pulses_before;
        int busy_seen;

        for (int i = 0; i < MUL_LAT; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        exp_res = modelSweep(M_EXACT);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");

        // Exact multiplier; mask changed mid-sweep must not reach mul_conf
        applyStimulus(M_EXACT, 6'b000111);
        repeat (50) @(posedge clk);
        #1;
        conf_in = 6'b111000;
        waitDone("exact");
        checkLiteral("exact", 0, 0, 0, 0, 0, 0);
        checkOutput("exact_mul_conf", longint'(mul_conf), longint'(6'b000111));

        // Zero multiplier: 15*15 nonzero products, sum 120*120=14400 saturates at 4095
        applyStimulus(M_ZERO, 6'b101010);
        waitDone("zero");
        checkLiteral("zero", 225, 0, 4095, 225, 15, 15);

        // Plus-one multiplier: every pair over by one, tie keeps (0,0)
        applyStimulus(M_PLUS1, 6'b000001);
        waitDone("plus1");
        checkLiteral("plus1", 256, 256, 256, 1, 0, 0);

        // LSB-cleared multiplier: only odd*odd pairs (8*8) err, first is (1,1)
        applyStimulus(M_CLR0, 6'b110011);
        waitDone("clr0");
        checkLiteral("clr0", 64, 0, 64, 1, 1, 1);

        // Results remain readable while idle
        repeat (10) @(negedge clk);
        checkLiteral("idle_hold", 64, 0, 64, 1, 1, 1);
        checkOutput("idle_busy", longint'(busy), 0);

        // Reset in the middle of a sweep aborts it with no done pulse
        applyStimulus(M_ZERO, 6'b011110);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        pulses_before = done_pulses;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("abort");
        repeat (BUSY_LEN) @(negedge clk);
        checkOutput("abort_no_done", longint'(done_pulses), longint'(pulses_before));
        checkOutput("abort_idle", longint'(busy), 0);

        // Clean sweep after the abort
        applyStimulus(M_PLUS1, 6'b000010);
        waitDone("after_abort");
        checkLiteral("after_abort", 256, 256, 256, 1, 0, 0);

        // start held high for the whole sweep: exactly one sweep, dropped in DONE
        @(posedge clk);
        #1;
        mode     = M_SET0;
        exp_res  = modelSweep(M_SET0);
        exp_conf = 6'b100001;
        conf_in  = 6'b100001;
        start    = 1'b1;
        pulses_before = done_pulses;
        waitDone("held");
        start = 1'b0;
        checkLiteral("held", 192, 192, 192, 1, 0, 0);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checkOutput("held_one_done", longint'(done_pulses - pulses_before), 1);
        checkOutput("held_no_resweep", longint'(busy_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/approx_mul_err_monitor.md
Name: approx_mul_err_monitor

Overview:
- On-chip exhaustive self-test engine for the approximate unsigned multipliers (unsigned_int_mul family).
- Sweeps every operand pair, drives the multiplier under test, and captures its result.
- Compares each result against an internally computed exact product and accumulates error metrics in hardware.
- Moves the error characterisation done today in simulation into silicon/FPGA, readable after a start/done handshake.

Parameters:
- WIDTH, 8, operand width; the sweep covers all 2^(2*WIDTH) pairs.
- MUL_LAT, 0, pipeline latency of the external multiplier in cycles (0 = combinational).
- CONF_W, 6, width of the Conf_Bit_Mask configuration word.
- SUM_W, 32, width of the error-distance accumulator.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- conf_in  in  CONF_W  configuration mask, latched on an accepted start.
- busy  out  1  high while a sweep or drain is in progress.
- done  out  1  one-cycle pulse when the results are final.
- mul_a  out  WIDTH  operand A to the multiplier under test (registered).
- mul_b  out  WIDTH  operand B to the multiplier under test (registered).
- mul_conf  out  CONF_W  latched mask driven to the multiplier's Conf_Bit_Mask.
- mul_r  in  2*WIDTH  approximate product returned by the multiplier.
- err_cnt  out  2*WIDTH+1  number of pairs where mul_r differs from the exact product.
- over_cnt  out  2*WIDTH+1  number of pairs where mul_r is greater than the exact product.
- sum_ed  out  SUM_W  sum of |exact - mul_r| over all pairs; saturates at all-ones.
- max_ed  out  2*WIDTH  largest single error distance seen.
- max_a  out  WIDTH  operand A of the first pair that reached max_ed.
- max_b  out  WIDTH  operand B of the first pair that reached max_ed.

Behaviour:
- Reset: all outputs 0 and state IDLE. A reset mid-sweep aborts the sweep immediately; done does not pulse.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 clears all accumulators, latches conf_in into mul_conf, sets mul_a=0 and mul_b=0, and moves to SWEEP.
  - busy rises on the same edge.
  - Results from the previous sweep stay readable until the next accepted start.
- SWEEP:
  - One pair is issued per cycle. mul_b increments each cycle; when it wraps from 2^WIDTH-1 to 0, mul_a increments (A outer loop, B inner loop).
  - After the pair (2^WIDTH-1, 2^WIDTH-1) has been issued, go to DRAIN.
  - start is ignored while busy.
- Operand alignment:
  - The issued operands travel through a MUL_LAT-deep delay line so they are aligned with mul_r.
  - The compare stage registers the aligned triple {a, b, mul_r}; the accumulators update one cycle later.
- DRAIN: lasts MUL_LAT+1 cycles to flush the delay line and the compare stage, then go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, then return to IDLE.
- Total busy duration: 2^(2*WIDTH) + MUL_LAT + 1 cycles. With default parameters this is 65537 cycles.
- Exact product: full 2*WIDTH-bit unsigned a*b, computed on the aligned operands.
- Error distance: ed = |exact - mul_r|, unsigned.
  - ed != 0 increments err_cnt.
  - mul_r > exact also increments over_cnt.
- max_ed update: replaced only when ed > max_ed (strictly greater), so a tie keeps the earliest pair; max_a/max_b update together with max_ed.
- Saturation: sum_ed saturates rather than wrapping. err_cnt and over_cnt cannot overflow at their width.

Optional Feature:
- Macro: ERR_MON_BIAS_EN.
- Defined:
  - Adds output bias_sum, signed, SUM_W+1 bits, accumulating (exact - mul_r) per pair with two's-complement saturation.
  - bias_sum clears on an accepted start and on reset.
- Undefined: no bias_sum port and no associated logic; all other behaviour is identical.

Test Plan:
- Exact model (mul_r = a*b), MUL_LAT=0, start pulse -> busy for 65537 cycles, done pulses once; err_cnt=0, over_cnt=0, sum_ed=0, max_ed=0, max_a=0, max_b=0.
- Zero model (mul_r = 0) -> err_cnt=65025, over_cnt=0, sum_ed=1065369600, max_ed=65025, max_a=255, max_b=255.
- Plus-one model (mul_r = a*b+1), MUL_LAT=3 -> err_cnt=65536, over_cnt=65536, sum_ed=65536, max_ed=1, max_a=0, max_b=0 (tie keeps the first pair); busy lasts 65540 cycles.
- Reset asserted at cycle 1000 of a sweep -> all outputs 0 on the next edge, state IDLE, no done pulse; a following start yields a clean full-sweep result.
- start held high for the entire sweep -> exactly one sweep and one done pulse; a second sweep starts only if start is still high in IDLE after DONE.
- conf_in=6'b000111 at the start edge, then changed mid-sweep -> mul_conf stays 6'b000111 for the whole sweep.
